// File: rtl/fft_mag_pkg.sv
// Shared constants for the FFT magnitude (integer square-root) pipeline.
package fft_mag_pkg;
  localparam int DW      = 12;
  localparam int AW      = 6;
  localparam int N_BINS  = 64;
  localparam int LATENCY = DW + 2;
endpackage

// File: rtl/isqrt_stage.sv
// One digit-by-digit square-root iteration: brings down two radicand bits,
// decides one root bit, and passes the request's valid/address along.
module isqrt_stage
  import fft_mag_pkg::*;
#(
  parameter int DW = fft_mag_pkg::DW,
  parameter int AW = fft_mag_pkg::AW,
  parameter int I  = 0
) (
  input  logic            vld,
  input  logic [AW-1:0]   addr,
  input  logic [2*DW-1:0] rad,
  input  logic [DW+2:0]   rem,
  input  logic [DW-1:0]   root,
  output logic            vld_nxt,
  output logic [AW-1:0]   addr_nxt,
  output logic [2*DW-1:0] rad_nxt,
  output logic [DW+2:0]   rem_nxt,
  output logic [DW-1:0]   root_nxt
);
  logic [DW+2:0] acc;
  logic [DW+2:0] trial;

  // Remainder never exceeds DW+1 significant bits, so the shift loses nothing.
  always_comb begin
    acc      = (rem << 2) | {{(DW+1){1'b0}}, rad[2*I +: 2]};
    trial    = {1'b0, root, 2'b01};
    vld_nxt  = vld;
    addr_nxt = addr;
    rad_nxt  = rad;
    if (acc >= trial) begin
      rem_nxt  = acc - trial;
      root_nxt = (root << 1) | {{(DW-1){1'b0}}, 1'b1};
    end else begin
      rem_nxt  = acc;
      root_nxt = root << 1;
    end
  end
endmodule

// File: rtl/fft_mag_sroot.sv
// Fully pipelined FFT bin magnitude: reads re/im per request, squares,
// then takes floor(sqrt) one bit per stage and writes the magnitude buffer.
module fft_mag_sroot
  import fft_mag_pkg::*;
#(
  parameter int DW = fft_mag_pkg::DW,
  parameter int AW = fft_mag_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sroot_en,
  input  logic [AW-1:0]        regfft_addr,
  input  logic signed [DW-1:0] regfft_re,
  input  logic signed [DW-1:0] regfft_im,
  output logic                 mag_wren,
  output logic [AW-1:0]        mag_addr,
  output logic [DW-1:0]        mag_data,
  output logic                 frame_done,
  output logic                 busy
);
  localparam int RW = DW + 3;

  function automatic logic [2*DW-1:0] mag_sq(input logic signed [DW-1:0] re,
                                              input logic signed [DW-1:0] im);
    logic signed [2*DW-1:0] re_w;
    logic signed [2*DW-1:0] im_w;
    re_w = re;
    im_w = im;
    return $unsigned(re_w * re_w) + $unsigned(im_w * im_w);
  endfunction

  logic                  vld_p0, vld_p1, vld_p2;
  logic [AW-1:0]         addr_p0, addr_p1, addr_p2;
  logic signed [DW-1:0]  re_p1, im_p1;
  logic [2*DW-1:0]       sq_p2;

  logic                  st_vld  [DW];
  logic [AW-1:0]         st_addr [DW];
  logic [2*DW-1:0]       st_rad  [DW];
  logic [RW-1:0]         st_rem  [DW];
  logic [DW-1:0]         st_root [DW];

  logic                  sr_vld  [DW-1];
  logic [AW-1:0]         sr_addr [DW-1];
  logic [2*DW-1:0]       sr_rad  [DW-1];
  logic [RW-1:0]         sr_rem  [DW-1];
  logic [DW-1:0]         sr_root [DW-1];

  // E0 request capture, E1 bank data capture, E2 squared magnitude
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      addr_p0 <= '0;
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      re_p1   <= '0;
      im_p1   <= '0;
      vld_p2  <= 1'b0;
      addr_p2 <= '0;
      sq_p2   <= '0;
    end else begin
      vld_p0  <= sroot_en;
      addr_p0 <= regfft_addr;
      vld_p1  <= vld_p0;
      addr_p1 <= addr_p0;
      re_p1   <= regfft_re;
      im_p1   <= regfft_im;
      vld_p2  <= vld_p1;
      addr_p2 <= addr_p1;
      sq_p2   <= mag_sq(re_p1, im_p1);
    end
  end

  // E3..E(DW+1) square-root iterations; the last iteration lands in the output register
  for (genvar k = 0; k < DW; k++) begin : g_sqrt
    logic            in_vld;
    logic [AW-1:0]   in_addr;
    logic [2*DW-1:0] in_rad;
    logic [RW-1:0]   in_rem;
    logic [DW-1:0]   in_root;

    if (k == 0) begin : g_first
      assign in_vld  = vld_p2;
      assign in_addr = addr_p2;
      assign in_rad  = sq_p2;
      assign in_rem  = '0;
      assign in_root = '0;
    end else begin : g_rest
      assign in_vld  = sr_vld[k-1];
      assign in_addr = sr_addr[k-1];
      assign in_rad  = sr_rad[k-1];
      assign in_rem  = sr_rem[k-1];
      assign in_root = sr_root[k-1];
    end

    isqrt_stage #(.DW(DW), .AW(AW), .I(DW-1-k)) u_stage (
      .vld      (in_vld),
      .addr     (in_addr),
      .rad      (in_rad),
      .rem      (in_rem),
      .root     (in_root),
      .vld_nxt  (st_vld[k]),
      .addr_nxt (st_addr[k]),
      .rad_nxt  (st_rad[k]),
      .rem_nxt  (st_rem[k]),
      .root_nxt (st_root[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DW-1; k++) begin
        sr_vld[k]  <= 1'b0;
        sr_addr[k] <= '0;
        sr_rad[k]  <= '0;
        sr_rem[k]  <= '0;
        sr_root[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DW-1; k++) begin
        sr_vld[k]  <= st_vld[k];
        sr_addr[k] <= st_addr[k];
        sr_rad[k]  <= st_rad[k];
        sr_rem[k]  <= st_rem[k];
        sr_root[k] <= st_root[k];
      end
    end
  end

  // E(DW+2) output register: address/data hold between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_wren   <= 1'b0;
      frame_done <= 1'b0;
      mag_addr   <= '0;
      mag_data   <= '0;
    end else begin
      mag_wren   <= st_vld[DW-1];
      frame_done <= st_vld[DW-1] && (st_addr[DW-1] == {AW{1'b1}});
      if (st_vld[DW-1]) begin
        mag_addr <= st_addr[DW-1];
        mag_data <= st_root[DW-1];
      end
    end
  end

  always_comb begin
    busy = vld_p0 | vld_p1 | vld_p2 | mag_wren;
    for (int k = 0; k < DW-1; k++) busy = busy | sr_vld[k];
  end
endmodule

// File: tb/tb_fft_mag_sroot.sv
// Self-checking bench for fft_mag_sroot: directed vector table, hand sequences
// and randomized traffic checked against a plain-arithmetic magnitude model.
module tb_fft_mag_sroot;
  import fft_mag_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 sroot_en = 1'b0;
  logic [AW-1:0]        regfft_addr = '0;
  logic signed [DW-1:0] regfft_re = '0;
  logic signed [DW-1:0] regfft_im = '0;
  logic                 mag_wren;
  logic [AW-1:0]        mag_addr;
  logic [DW-1:0]        mag_data;
  logic                 frame_done;
  logic                 busy;

  always #5 clk = ~clk;

  fft_mag_sroot #(.DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sroot_en    (sroot_en),
    .regfft_addr (regfft_addr),
    .regfft_re   (regfft_re),
    .regfft_im   (regfft_im),
    .mag_wren    (mag_wren),
    .mag_addr    (mag_addr),
    .mag_data    (mag_data),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  // Register bank model: data for the address appears one cycle later.
  logic signed [DW-1:0] bank_re [N_BINS];
  logic signed [DW-1:0] bank_im [N_BINS];
  always @(posedge clk) begin
    regfft_re <= bank_re[regfft_addr];
    regfft_im <= bank_im[regfft_addr];
  end

  typedef struct { int addr; int mag; int issue; } exp_t;
  typedef struct { int re; int im; int addr; int mag; } vec_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_wr = 0;
  int   n_fd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_mag(input int re, input int im);
    int s, lo, hi, mid;
    s  = re * re + im * im;
    lo = 0;
    hi = 1 << DW;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= s) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  task automatic drive(input logic en, input int a);
    @(negedge clk);
    sroot_en    = en;
    regfft_addr = AW'(a);
    if (en) q.push_back('{a, ref_mag(int'(bank_re[a]), int'(bank_im[a])), cyc + 1});
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((q.size() != 0 || busy) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_complete", (q.size() == 0 && !busy), 1);
  endtask

  task automatic randomize_bank();
    for (int i = 0; i < N_BINS; i++) begin
      bank_re[i] = DW'($urandom);
      bank_im[i] = DW'($urandom);
    end
  endtask

  // Output monitor: every write must match the oldest outstanding request.
  exp_t e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mag_wren) begin
        n_wr++;
        if (frame_done) n_fd++;
        if (q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = q.pop_front();
          chk("mon_addr", mag_addr, e.addr);
          chk("mon_data", mag_data, e.mag);
          chk("mon_latency", cyc - e.issue, LATENCY);
          chk("mon_frame_done", frame_done, (e.addr == N_BINS - 1));
        end
      end else begin
        chk("idle_frame_done", frame_done, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[9];
    int   iss, t, c0, wr0, fd0;

    tbl[0] = '{3, 4, 5, 5};
    tbl[1] = '{-2048, -2048, 7, 2896};
    tbl[2] = '{2047, 0, 9, 2047};
    tbl[3] = '{1, 1, 63, 1};
    tbl[4] = '{0, 0, 0, 0};
    tbl[5] = '{-2048, 0, 1, 2048};
    tbl[6] = '{2047, 2047, 2, 2894};
    tbl[7] = '{-5, 12, 40, 13};
    tbl[8] = '{-1, -1, 62, 1};

    for (int i = 0; i < N_BINS; i++) begin
      bank_re[i] = '0;
      bank_im[i] = '0;
    end

    repeat (2) @(negedge clk);
    chk("reset_wren", mag_wren, 0);
    chk("reset_addr", mag_addr, 0);
    chk("reset_data", mag_data, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      bank_re[tbl[i].addr] = DW'(tbl[i].re);
      bank_im[tbl[i].addr] = DW'(tbl[i].im);
      drive(1'b1, tbl[i].addr);
      iss = cyc + 1;
      drive(1'b0, 0);
      t = 0;
      while (!mag_wren && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (!mag_wren) chk("tbl_write_seen", 0, 1);
      else begin
        chk("tbl_data", mag_data, tbl[i].mag);
        chk("tbl_addr", mag_addr, tbl[i].addr);
        chk("tbl_latency", cyc - iss, LATENCY);
        chk("tbl_frame_done", frame_done, (tbl[i].addr == N_BINS - 1));
      end
      @(negedge clk);
    end
    wait_drain();

    // Request, bubble, request: two writes one idle cycle apart, busy held high
    randomize_bank();
    drive(1'b1, 10);
    c0 = cyc + 1;
    drive(1'b0, 0);
    drive(1'b1, 11);
    drive(1'b0, 0);
    while (cyc <= c0 + 16) begin
      chk("seq_busy_high", busy, 1);
      if (cyc == c0 + 14 || cyc == c0 + 16) chk("seq_write", mag_wren, 1);
      if (cyc == c0 + 15) chk("seq_gap", mag_wren, 0);
      @(negedge clk);
    end
    chk("seq_busy_low", busy, 0);
    chk("seq_wren_low", mag_wren, 0);
    wait_drain();

    // Full back-to-back frame with random data
    randomize_bank();
    wr0 = n_wr;
    fd0 = n_fd;
    for (int a = 0; a < N_BINS; a++) drive(1'b1, a);
    drive(1'b0, 0);
    wait_drain();
    chk("frame_writes", n_wr - wr0, N_BINS);
    chk("frame_done_count", n_fd - fd0, 1);

    // Random enables with repeated and out-of-order addresses
    randomize_bank();
    for (int i = 0; i < 80; i++) drive(1'($urandom_range(0, 1)), int'($urandom_range(0, N_BINS - 1)));
    drive(1'b0, 0);
    wait_drain();

    // 62, 63, then a wrapped 0 without enable
    wr0 = n_wr;
    fd0 = n_fd;
    drive(1'b1, 62);
    drive(1'b1, 63);
    drive(1'b0, 0);
    wait_drain();
    chk("wrap_writes", n_wr - wr0, 2);
    chk("wrap_frame_done", n_fd - fd0, 1);

    // Reset in the middle of a frame
    randomize_bank();
    for (int a = 0; a < 20; a++) drive(1'b1, a);
    @(negedge clk);
    sroot_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_wren", mag_wren, 0);
    chk("midrst_addr", mag_addr, 0);
    chk("midrst_data", mag_data, 0);
    chk("midrst_frame_done", frame_done, 0);
    chk("midrst_busy", busy, 0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr0 = n_wr;
    repeat (30) @(negedge clk);
    chk("post_reset_writes", n_wr - wr0, 0);
    chk("post_reset_busy", busy, 0);

    // Pipeline still healthy after reset
    drive(1'b1, 3);
    drive(1'b0, 0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
